usb_fifo_frame_reader: RTL and testbench

USB_FIFO_FRAME_READER -- requirements
Module: usb_fifo_frame_reader

---
 rtl/usb_fifo_frame_reader.sv | 174 +++++++++++++++++
 tb/tb_usb_fifo_frame_reader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fifo_frame_reader.sv
// usb_fifo_frame_reader
// Reads 4-byte stereo frames from an FT245-style USB FIFO and presents them
// as a held left/right sample pair with a valid/ready handshake for the I2S side.
// Byte order on the wire: left[7:0], left[15:8], right[7:0], right[15:8].
// Optional feature: define UNDERRUN_COUNT_EN to build a saturating 16-bit
// counter of starvation events. Without it, underrun_count is tied to zero.
module usb_fifo_frame_reader #(
  parameter int RD_PULSE   = 3,
  parameter int RD_RECOVER = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_rxf_n,
  output logic        fifo_rd_n,
  output logic [15:0] sample_left,
  output logic [15:0] sample_right,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        underrun,
  output logic [15:0] underrun_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_LOW   = 2'd1,
    RD_HIGH  = 2'd2,
    WAIT_OUT = 2'd3
  } state_t;

  localparam logic [7:0] PULSE_LAST   = 8'(RD_PULSE - 1);
  localparam logic [7:0] RECOVER_LAST = 8'(RD_RECOVER - 1);

  state_t          state;
  state_t          state_next;
  logic [1:0]      rxf_sync;
  logic [1:0]      byte_idx;
  logic [1:0]      byte_idx_next;
  logic [7:0]      phase;
  logic [7:0]      phase_next;
  logic [3:0][7:0] asm_bytes;
  logic            capture;
  logic            load;
  logic            out_free;

  // The held frame can be replaced when nothing is held or it is leaving this cycle.
  assign out_free = !frame_valid || frame_ready;

  // Two-flop synchronizer for the asynchronous RXF flag; idles at "no data".
  always_ff @(posedge clk) begin
    if (rst) begin
      rxf_sync <= 2'b11;
    end else begin
      rxf_sync <= {rxf_sync[0], fifo_rxf_n};
    end
  end

  // Next-state logic: byte read sequencing, frame completion and output back-pressure.
  always_comb begin
    state_next    = state;
    phase_next    = phase;
    byte_idx_next = byte_idx;
    capture       = 1'b0;
    load          = 1'b0;
    case (state)
      IDLE: begin
        if (!rxf_sync[1]) begin
          state_next = RD_LOW;
          phase_next = 8'd0;
        end
      end
      RD_LOW: begin
        if (phase == PULSE_LAST) begin
          capture    = 1'b1;
          state_next = RD_HIGH;
          phase_next = 8'd0;
        end else begin
          phase_next = phase + 8'd1;
        end
      end
      RD_HIGH: begin
        if (phase == RECOVER_LAST) begin
          phase_next    = 8'd0;
          byte_idx_next = byte_idx + 2'd1;
          if (byte_idx != 2'd3) begin
            state_next = IDLE;
          end else if (out_free) begin
            load       = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT_OUT;
          end
        end else begin
          phase_next = phase + 8'd1;
        end
      end
      WAIT_OUT: begin
        if (out_free) begin
          load       = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; the read strobe is registered off the next state so it moves with the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= 8'd0;
      byte_idx  <= 2'd0;
      fifo_rd_n <= 1'b1;
    end else begin
      state     <= state_next;
      phase     <= phase_next;
      byte_idx  <= byte_idx_next;
      fifo_rd_n <= (state_next != RD_LOW);
    end
  end

  // Assembly buffer; cleared on reset so a partial frame never leaks out.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_bytes <= '0;
    end else if (capture) begin
      asm_bytes[byte_idx] <= fifo_data;
    end
  end

  // Held output frame and its valid flag; a load wins over a consume on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_left  <= 16'd0;
      sample_right <= 16'd0;
      frame_valid  <= 1'b0;
    end else if (load) begin
      sample_left  <= {asm_bytes[1], asm_bytes[0]};
      sample_right <= {asm_bytes[3], asm_bytes[2]};
      frame_valid  <= 1'b1;
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

  // One-cycle starvation pulse when the consumer asks with nothing held.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun <= 1'b0;
    end else begin
      underrun <= frame_ready && !frame_valid;
    end
  end

`ifdef UNDERRUN_COUNT_EN
  logic [15:0] underrun_count_q;

  // Saturating tally of starvation pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_count_q <= 16'd0;
    end else if (underrun && (underrun_count_q != 16'hFFFF)) begin
      underrun_count_q <= underrun_count_q + 16'd1;
    end
  end

  assign underrun_count = underrun_count_q;
`else
  assign underrun_count = 16'd0;
`endif

endmodule

// File: tb/tb_usb_fifo_frame_reader.sv
// tb_usb_fifo_frame_reader
// Bench for usb_fifo_frame_reader with a small FT245 FIFO model and a frame
// scoreboard. Define UNDERRUN_COUNT_EN to exercise the underrun counter.
module tb_usb_fifo_frame_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  fifo_data;
  logic        fifo_rxf_n;
  logic        fifo_rd_n;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        frame_valid;
  logic        frame_ready;
  logic        underrun;
  logic [15:0] underrun_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // FIFO model storage: the bench writes wr_ptr/flush_req, the model owns rd_ptr.
  logic [7:0]  fifo_mem [256];
  int          wr_ptr    = 0;
  int          rd_ptr    = 0;
  int          flush_req = 0;
  int          flush_ack = 0;
  logic        mon_prev  = 1'b1;
  logic        popped;
  int          low_len   = 0;
  int          pulse_lens[$];
  int          fall_cycles[$];
  logic [31:0] exp_q[$];

  usb_fifo_frame_reader dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_data      (fifo_data),
    .fifo_rxf_n     (fifo_rxf_n),
    .fifo_rd_n      (fifo_rd_n),
    .sample_left    (sample_left),
    .sample_right   (sample_right),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // FT245 model: a byte is consumed when RD# rises, RXF# blinks high for a cycle
  // afterwards, and RD# pulse widths and fall times are recorded.
  always @(negedge clk) begin
    #1;
    popped = 1'b0;
    if (flush_ack != flush_req) begin
      rd_ptr    = wr_ptr;
      flush_ack = flush_req;
    end
    if (mon_prev === 1'b0 && fifo_rd_n === 1'b1) begin
      pulse_lens.push_back(low_len);
      low_len = 0;
      if (rd_ptr != wr_ptr) begin
        rd_ptr++;
        popped = 1'b1;
      end
    end else if (fifo_rd_n === 1'b0) begin
      if (mon_prev === 1'b1) fall_cycles.push_back(cyc);
      low_len++;
    end
    mon_prev   = fifo_rd_n;
    fifo_rxf_n = (rd_ptr == wr_ptr) || popped;
    fifo_data  = fifo_mem[rd_ptr % 256];
  end

  task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
    fifo_mem[wr_ptr % 256] = l[7:0];
    wr_ptr++;
    fifo_mem[wr_ptr % 256] = l[15:8];
    wr_ptr++;
    fifo_mem[wr_ptr % 256] = r[7:0];
    wr_ptr++;
    fifo_mem[wr_ptr % 256] = r[15:8];
    wr_ptr++;
    exp_q.push_back({l, r});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    frame_ready = 1'b0;
    flush_req++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_xfer(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (frame_valid === 1'b1 && frame_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    frame_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (fifo_rd_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_rd_n: got %b expected 1", fifo_rd_n); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", frame_valid); end
    checks++; if (sample_left !== 16'h0000) begin failures++; $display("[TB] FAIL reset_left: got %h expected 0000", sample_left); end
    checks++; if (sample_right !== 16'h0000) begin failures++; $display("[TB] FAIL reset_right: got %h expected 0000", sample_right); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun); end
    checks++; if (underrun_count !== 16'h0000) begin failures++; $display("[TB] FAIL reset_count: got %h expected 0000", underrun_count); end
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    int p0, f0, n0;
    bit ok;
    logic [31:0] e;
    do_reset();
    frame_ready = 1'b1;
    p0 = pulse_lens.size();
    f0 = fall_cycles.size();
    n0 = cyc;
    push_frame(16'h1234, 16'h5678);
    wait_xfer(300, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL single_timeout: got no frame expected one within 300 cycles"); end
    if (ok) begin
      e = exp_q.pop_front();
      checks++; if (sample_left !== e[31:16]) begin failures++; $display("[TB] FAIL single_left: got %h expected %h", sample_left, e[31:16]); end
      checks++; if (sample_right !== e[15:0]) begin failures++; $display("[TB] FAIL single_right: got %h expected %h", sample_right, e[15:0]); end
      @(negedge clk);
      checks++; if (frame_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_consume_clear: got %b expected 0", frame_valid); end
    end
    checks++; if (pulse_lens.size() - p0 != 4) begin failures++; $display("[TB] FAIL single_pulse_count: got %0d expected 4", pulse_lens.size() - p0); end
    if (fall_cycles.size() - f0 >= 1) begin
      checks++; if (fall_cycles[f0] - n0 != 3) begin failures++; $display("[TB] FAIL first_fall_latency: got %0d expected 3", fall_cycles[f0] - n0); end
    end
    for (int i = 0; i < 4; i++) begin
      if (p0 + i < pulse_lens.size()) begin
        checks++; if (pulse_lens[p0 + i] != 3) begin failures++; $display("[TB] FAIL pulse_width%0d: got %0d expected 3", i, pulse_lens[p0 + i]); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (f0 + i + 1 < fall_cycles.size()) begin
        checks++; if (fall_cycles[f0 + i + 1] - fall_cycles[f0 + i] != 7) begin failures++; $display("[TB] FAIL byte_period%0d: got %0d expected 7", i, fall_cycles[f0 + i + 1] - fall_cycles[f0 + i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok, bad;
    logic [31:0] e1, e2;
    do_reset();
    frame_ready = 1'b0;
    push_frame(16'hA1B2, 16'hC3D4);
    push_frame(16'h1357, 16'h2468);
    push_frame(16'h9ABC, 16'hDEF0);
    e1 = exp_q[0];
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (wr_ptr - rd_ptr == 4) begin ok = 1'b1; break; end
    end
    checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL park_timeout: got %0d bytes pending expected 4", wr_ptr - rd_ptr); end
    repeat (10) @(negedge clk);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rd_n !== 1'b1 || frame_valid !== 1'b1 || sample_left !== e1[31:16] || sample_right !== e1[15:0]) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("[TB] FAIL hold_stable: got rd_n=%b valid=%b %h/%h expected rd_n=1 valid=1 %h/%h", fifo_rd_n, frame_valid, sample_left, sample_right, e1[31:16], e1[15:0]); end
    checks++; if (wr_ptr - rd_ptr != 4) begin failures++; $display("[TB] FAIL park_no_read: got %0d bytes pending expected 4", wr_ptr - rd_ptr); end
    e1 = exp_q.pop_front();
    checks++; if (sample_left !== e1[31:16] || sample_right !== e1[15:0]) begin failures++; $display("[TB] FAIL xfer1: got %h/%h expected %h/%h", sample_left, sample_right, e1[31:16], e1[15:0]); end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    e2 = exp_q[0];
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("[TB] FAIL swap_valid: got %b expected 1", frame_valid); end
    checks++; if (sample_left !== e2[31:16] || sample_right !== e2[15:0]) begin failures++; $display("[TB] FAIL swap_frame2: got %h/%h expected %h/%h", sample_left, sample_right, e2[31:16], e2[15:0]); end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_ptr == rd_ptr) begin ok = 1'b1; break; end
    end
    checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL resume_read: got %0d bytes pending expected 0", wr_ptr - rd_ptr); end
  endtask

  task automatic test_underrun();
    int pulses;
    logic first;
    do_reset();
    @(negedge clk);
    pulses = 0;
    first = 1'b0;
    frame_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) first = underrun;
      if (underrun === 1'b1) pulses++;
    end
    frame_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (underrun === 1'b1) pulses++;
    end
    checks++; if (first !== 1'b1) begin failures++; $display("[TB] FAIL underrun_latency: got %b expected 1", first); end
    checks++; if (pulses != 5) begin failures++; $display("[TB] FAIL underrun_pulses: got %0d expected 5", pulses); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL underrun_idle: got %b expected 0", underrun); end
`ifdef UNDERRUN_COUNT_EN
    checks++; if (underrun_count !== 16'd5) begin failures++; $display("[TB] FAIL underrun_count: got %0d expected 5", underrun_count); end
`else
    checks++; if (underrun_count !== 16'd0) begin failures++; $display("[TB] FAIL underrun_count: got %0d expected 0", underrun_count); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int nf;
    logic prev;
    bit ok;
    logic [31:0] e;
    do_reset();
    frame_ready = 1'b1;
    push_frame(16'hBBAA, 16'hDDCC);
    nf = 0;
    prev = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && fifo_rd_n === 1'b0) nf++;
      prev = fifo_rd_n;
      if (nf == 3) begin ok = 1'b1; break; end
    end
    checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL mid_timeout: got %0d read pulses expected 3", nf); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (fifo_rd_n !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset_rd_n: got %b expected 1", fifo_rd_n); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_valid: got %b expected 0", frame_valid); end
    rst = 1'b0;
    flush_req++;
    exp_q.delete();
    repeat (3) @(negedge clk);
    push_frame(16'h0201, 16'h0403);
    wait_xfer(300, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL fresh_timeout: got no frame expected one within 300 cycles"); end
    if (ok) begin
      e = exp_q.pop_front();
      checks++; if (sample_left !== e[31:16] || sample_right !== e[15:0]) begin failures++; $display("[TB] FAIL fresh_frame: got %h/%h expected %h/%h", sample_left, sample_right, e[31:16], e[15:0]); end
    end
  endtask

`ifdef UNDERRUN_COUNT_EN
  task automatic test_count_saturate();
    do_reset();
    @(negedge clk);
    force dut.underrun_count_q = 16'hFFFE;
    #1;
    release dut.underrun_count_q;
    frame_ready = 1'b1;
    repeat (3) @(negedge clk);
    frame_ready = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (underrun_count !== 16'hFFFF) begin failures++; $display("[TB] FAIL count_saturate: got %h expected ffff", underrun_count); end
  endtask
`endif

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    frame_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_reset_mid_frame();
`ifdef UNDERRUN_COUNT_EN
    test_count_saturate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
